bit_serial_subtractor: RTL and testbench

//  Multi-cycle N-bit subtractor: computes diff = a - b - bin one bit per clock, LSB first.

---
 rtl/bit_serial_subtractor.sv | 130 +++++++++++++
 tb/tb_bit_serial_subtractor.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_subtractor.sv
// bit_serial_subtractor
//   Multi-cycle subtractor: diff = a - b - bin (mod 2^WIDTH), one bit per clock,
//   LSB first, using a single full-subtractor stage and a registered borrow.
//   A start/busy/done handshake lets a controller launch one operation at a time.
//
// Optional build macro: BSS_SIGNED_OVF_EN adds the ovf output (signed overflow).
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous, active-high reset
//   start  in   1      launch request, sampled in IDLE and DONE only
//   a      in   WIDTH  minuend, captured when start is accepted
//   b      in   WIDTH  subtrahend, captured when start is accepted
//   bin    in   1      borrow-in, captured when start is accepted
//   busy   out  1      high while bits are being processed
//   done   out  1      one-cycle pulse, diff/bout hold a fresh result
//   diff   out  WIDTH  result, held until the next completion
//   ovf    out  1      signed overflow (only with BSS_SIGNED_OVF_EN)
//   bout   out  1      final borrow-out
//
// State | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for start
// RUN   | one result bit per cycle, cnt counts processed bits
// DONE  | result registers just updated; start here relaunches
module bit_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef BSS_SIGNED_OVF_EN
  output logic             ovf,
`endif
  output logic             bout
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic [CNT_W-1:0] cnt;
  logic             brw;

  logic accept, last, bit_d, brw_next;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        accept = start;
        if (start) state_next = RUN;
      end
      RUN: begin
        last = (cnt == CNT_W'(WIDTH - 1));
        if (last) state_next = DONE;
      end
      DONE: begin
        accept     = start;
        state_next = start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Full-subtractor cell on the current LSBs.
  always_comb begin
    bit_d    = a_sh[0] ^ b_sh[0] ^ brw;
    brw_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      brw    <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
`ifdef BSS_SIGNED_OVF_EN
      ovf    <= 1'b0;
`endif
    end else if (accept) begin
      a_sh <= a;
      b_sh <= b;
      brw  <= bin;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= {bit_d, res_sh[WIDTH-1:1]};
      brw    <= brw_next;
      cnt    <= cnt + 1'b1;
      if (last) begin
        // The final bit goes straight to diff; res_sh would only hold it a cycle later.
        diff <= {bit_d, res_sh[WIDTH-1:1]};
        bout <= brw_next;
`ifdef BSS_SIGNED_OVF_EN
        // brw is the borrow into the MSB during the last bit.
        ovf  <= brw ^ brw_next;
`endif
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_bit_serial_subtractor.sv
module tb_bit_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic         busy, done, bout;
  logic [W-1:0] diff;
`ifdef BSS_SIGNED_OVF_EN
  logic         ovf;
`endif

  int checks   = 0;
  int failures = 0;

  bit_serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
`ifdef BSS_SIGNED_OVF_EN
    .ovf  (ovf),
`endif
    .bout (bout)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic.
  function automatic logic [W-1:0] ref_diff(input int ia, input int ib, input int ibin);
    int r;
    r = ia - ib - ibin;
    return W'(r & ((1 << W) - 1));
  endfunction

  function automatic logic ref_bout(input int ia, input int ib, input int ibin);
    return (ia < ib + ibin);
  endfunction

  function automatic logic ref_ovf(input int ia, input int ib, input int ibin);
    int sa, sb, r;
    sa = (ia >= (1 << (W - 1))) ? ia - (1 << W) : ia;
    sb = (ib >= (1 << (W - 1))) ? ib - (1 << W) : ib;
    r  = sa - sb - ibin;
    return (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
  endfunction

  // Launches one operation and waits (bounded) for done; returns at the done cycle.
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                       output int busy_n, output int lat, output bit timed_out);
    @(negedge clk);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    busy_n = busy ? 1 : 0;
    lat = 1;
    while (!done && lat < 4 * W) begin
      @(negedge clk);
      lat++;
      if (busy) busy_n++;
    end
    timed_out = !done;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, bout} !== 3'b000 || diff !== '0) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b diff=%h bout=%b, required all 0", busy, done, diff, bout);
    end
`ifdef BSS_SIGNED_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_ovf: ovf=%b required 0", ovf);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic ibin);
    int busy_n, lat;
    bit to;
    logic [W-1:0] ed;
    logic eb;
    do_op(ia, ib, ibin, busy_n, lat, to);
    ed = ref_diff(int'(ia), int'(ib), int'(ibin));
    eb = ref_bout(int'(ia), int'(ib), int'(ibin));
    checks++;
    if (to || lat != W + 1 || busy_n != W) begin
      failures++;
      $display("FAIL %s_timing: timeout=%0d latency=%0d busy_cycles=%0d, required latency=%0d busy=%0d",
               name, to, lat, busy_n, W + 1, W);
    end
    checks++;
    if (diff !== ed || bout !== eb) begin
      failures++;
      $display("FAIL %s_result: a=%h b=%h bin=%b diff=%h bout=%b, required diff=%h bout=%b",
               name, ia, ib, ibin, diff, bout, ed, eb);
    end
`ifdef BSS_SIGNED_OVF_EN
    checks++;
    if (ovf !== ref_ovf(int'(ia), int'(ib), int'(ibin))) begin
      failures++;
      $display("FAIL %s_ovf: a=%h b=%h bin=%b ovf=%b required %b",
               name, ia, ib, ibin, ovf, ref_ovf(int'(ia), int'(ib), int'(ibin)));
    end
`endif
    // done must be a single-cycle pulse
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL %s_done_pulse: done=%b after done cycle, required 0", name, done);
    end
  endtask

  task automatic test_directed();
    check_op("dir_5m3", 8'h05, 8'h03, 1'b0);
    check_op("dir_3m5", 8'h03, 8'h05, 1'b0);
    check_op("dir_0m0b", 8'h00, 8'h00, 1'b1);
    check_op("dir_80m01", 8'h80, 8'h01, 1'b0);
    check_op("dir_7Fm FF", 8'h7F, 8'hFF, 1'b0);
    check_op("dir_10m01", 8'h10, 8'h01, 1'b0);
    check_op("dir_FFmFFb", 8'hFF, 8'hFF, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      check_op("rand", W'($urandom), W'($urandom), 1'($urandom));
  endtask

  task automatic test_start_ignored();
    int lat;
    @(negedge clk);
    a = 8'h9C; b = 8'h21; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 4 * W) begin
      @(negedge clk);
      lat++;
      if (lat == 3) begin a = 8'h11; b = 8'h77; bin = 1'b0; start = 1'b1; end
      else start = 1'b0;
    end
    checks++;
    if (lat != W + 1 || diff !== ref_diff(8'h9C, 8'h21, 1) || bout !== ref_bout(8'h9C, 8'h21, 1)) begin
      failures++;
      $display("FAIL start_ignored: latency=%0d diff=%h bout=%b, required latency=%0d diff=%h bout=%b",
               lat, diff, bout, W + 1, ref_diff(8'h9C, 8'h21, 1), ref_bout(8'h9C, 8'h21, 1));
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL start_ignored_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [W-1:0] a1, b1, a2, b2;
    logic bin1, bin2;
    bit held_ok;
    a1 = W'($urandom); b1 = W'($urandom); bin1 = 1'($urandom);
    a2 = W'($urandom); b2 = W'($urandom); bin2 = 1'($urandom);
    @(negedge clk);
    a = a1; b = b1; bin = bin1; start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 4 * W);
    checks++;
    if (!done || diff !== ref_diff(a1, b1, bin1) || bout !== ref_bout(a1, b1, bin1)) begin
      failures++;
      $display("FAIL b2b_first: done=%b diff=%h bout=%b, required done=1 diff=%h bout=%b",
               done, diff, bout, ref_diff(a1, b1, bin1), ref_bout(a1, b1, bin1));
    end
    a = a2; b = b2; bin = bin2;
    lat = 0;
    held_ok = 1'b1;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (!done && (diff !== ref_diff(a1, b1, bin1) || bout !== ref_bout(a1, b1, bin1)))
        held_ok = 1'b0;
    end while (!done && lat < 4 * W);
    checks++;
    if (lat != W + 1) begin
      failures++;
      $display("FAIL b2b_spacing: done spacing=%0d cycles, required %0d", lat, W + 1);
    end
    checks++;
    if (!held_ok) begin
      failures++;
      $display("FAIL b2b_hold: diff/bout changed during second run, required %h/%b held",
               ref_diff(a1, b1, bin1), ref_bout(a1, b1, bin1));
    end
    checks++;
    if (diff !== ref_diff(a2, b2, bin2) || bout !== ref_bout(a2, b2, bin2)) begin
      failures++;
      $display("FAIL b2b_second: diff=%h bout=%b, required diff=%h bout=%b",
               diff, bout, ref_diff(a2, b2, bin2), ref_bout(a2, b2, bin2));
    end
  endtask

  task automatic test_reset_mid_run();
    int done_seen;
    check_op("pre_rst", 8'h05, 8'h03, 1'b0);
    @(negedge clk);
    a = 8'h40; b = 8'h01; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, bout} !== 3'b000 || diff !== '0) begin
      failures++;
      $display("FAIL reset_mid_run: busy=%b done=%b diff=%h bout=%b, required all 0",
               busy, done, diff, bout);
    end
    rst = 1'b0;
    done_seen = 0;
    repeat (W + 3) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      failures++;
      $display("FAIL reset_abort: busy/done seen %0d cycles after abort, required 0", done_seen);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    check_op("post_rst", 8'hA5, 8'h5A, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
